// File: rtl/reg32_ser_pkg.sv
// rtl/reg32_ser_pkg.sv - shared types and defaults for the 32-bit register serializer
package reg32_ser_pkg;

  localparam int REG32_SER_DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } ser_state_e;

endpackage

// File: rtl/reg32_piso.sv
// rtl/reg32_piso.sv - parallel-load shift-left register, MSB out, optional running XOR (REG32_SERIAL_PARITY_EN)
module reg32_piso
  import reg32_ser_pkg::*;
#(
  parameter int WIDTH = REG32_SER_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
`ifdef REG32_SERIAL_PARITY_EN
  output logic             parity_o,
`endif
  output logic             msb_o
);

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb_o = sr_q[WIDTH-1];

`ifdef REG32_SERIAL_PARITY_EN
  // Accumulates each bit as it leaves, so after WIDTH shifts it holds the word's XOR.
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (load_i) begin
      par_d = 1'b0;
    end else if (shift_i) begin
      par_d = par_q ^ sr_q[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign parity_o = par_q;
`endif

endmodule

// File: rtl/reg32_serializer.sv
// rtl/reg32_serializer.sv - MSB-first serial transmitter for register words; REG32_SERIAL_PARITY_EN appends even parity
module reg32_serializer
  import reg32_ser_pkg::*;
#(
  parameter int WIDTH = REG32_SER_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  input  logic             load_i,
  output logic             busy_o,
  output logic             ser_out_o,
  output logic             ser_valid_o,
  output logic             frame_end_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_en, shift_en, msb;
`ifdef REG32_SERIAL_PARITY_EN
  logic             par_bit;
`endif

  reg32_piso #(.WIDTH(WIDTH)) u_piso (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load_en),
    .shift_i (shift_en),
    .data_i  (data_i),
`ifdef REG32_SERIAL_PARITY_EN
    .parity_o(par_bit),
`endif
    .msb_o   (msb)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_en  = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_i) begin
          load_en = 1'b1;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
`ifdef REG32_SERIAL_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef REG32_SERIAL_PARITY_EN
      ST_PARITY: state_d = ST_DONE;
`endif
      ST_DONE: begin
        // The edge leaving DONE may start the next frame, giving a WIDTH+1 (or +2) period.
        if (load_i) begin
          load_en = 1'b1;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    ser_out_o = 1'b0;
    case (state_q)
      ST_SHIFT:  ser_out_o = msb;
`ifdef REG32_SERIAL_PARITY_EN
      ST_PARITY: ser_out_o = par_bit;
`endif
      default:   ser_out_o = 1'b0;
    endcase
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign ser_valid_o = (state_q == ST_SHIFT) || (state_q == ST_PARITY);
  assign frame_end_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_reg32_serializer.sv
// tb/tb_reg32_serializer.sv - self-checking bench with a queue-based frame model for reg32_serializer
module tb_reg32_serializer;

  localparam int W = 32;
`ifdef REG32_SERIAL_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load_i = 1'b0;
  logic [W-1:0] data_i = '0;
  logic         busy_o, ser_out_o, ser_valid_o, frame_end_o;

  reg32_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_i     (data_i),
    .load_i     (load_i),
    .busy_o     (busy_o),
    .ser_out_o  (ser_out_o),
    .ser_valid_o(ser_valid_o),
    .frame_end_o(frame_end_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic busy;
    logic sout;
    logic sval;
    logic fend;
  } obs_t;

  obs_t exp_q[$];
  obs_t exp_cur = '0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic stream[$];
  int   fe_cyc[$];
  int   sv_rise[$];
  logic prev_sv = 1'b0;

  function automatic obs_t mk(input logic b, input logic s, input logic v, input logic f);
    obs_t o;
    o.busy = b;
    o.sout = s;
    o.sval = v;
    o.fend = f;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, req);
    end
  endtask

  // Model: a frame is a list of output tuples queued on acceptance and replayed one per edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_cur = '0;
    end else begin
      if (exp_q.size() == 0 && load_i === 1'b1) begin
        for (int i = 0; i < W; i++) exp_q.push_back(mk(1'b1, data_i[W-1-i], 1'b1, 1'b0));
        if (PAR != 0) exp_q.push_back(mk(1'b1, ^data_i, 1'b1, 1'b0));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1));
      end
      if (exp_q.size() > 0) exp_cur = exp_q.pop_front();
      else exp_cur = '0;
    end
  end

  always @(negedge clk) begin
    cyc++;
    check("busy", busy_o, exp_cur.busy);
    check("ser_out", ser_out_o, exp_cur.sout);
    check("ser_valid", ser_valid_o, exp_cur.sval);
    check("frame_end", frame_end_o, exp_cur.fend);
    if (ser_valid_o === 1'b1) stream.push_back(ser_out_o);
    if (frame_end_o === 1'b1) fe_cyc.push_back(cyc);
    if (ser_valid_o === 1'b1 && prev_sv !== 1'b1) sv_rise.push_back(cyc);
    prev_sv = ser_valid_o;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    stream.delete();
    fe_cyc.delete();
    sv_rise.delete();
  endtask

  function automatic logic [31:0] word_at(input int off);
    logic [31:0] w = '0;
    for (int i = 0; i < 32; i++) w = {w[30:0], (off + i < stream.size()) ? stream[off+i] : 1'b0};
    return w;
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_o !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    check({name, "_idle_timeout"}, (n < 200), 1);
  endtask

  task automatic send(input logic [W-1:0] d);
    load_i = 1'b1;
    data_i = d;
    step();
    load_i = 1'b0;
  endtask

  initial begin
    logic [W-1:0] a, b;
    int n;

    // Reset and quiet idle
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    step();
    check("rst_busy", busy_o, 0);
    check("rst_ser_out", ser_out_o, 0);
    check("rst_ser_valid", ser_valid_o, 0);
    check("rst_frame_end", frame_end_o, 0);

    // Alternating pattern
    clear_obs();
    send(32'h5555_5555);
    check("t2_busy_up", busy_o, 1);
    check("t2_first_bit", ser_out_o, 0);
    wait_idle("t2");
    check("t2_nbits", stream.size(), W + PAR);
    check("t2_word", word_at(0), 32'h5555_5555);
    check("t2_fe_count", fe_cyc.size(), 1);
    check("t2_fe_pos", fe_cyc[0] - sv_rise[0], W + PAR);
`ifdef REG32_SERIAL_PARITY_EN
    check("t2_parity", stream[W], 0);
`endif

    // Load held high with changing data: second word waits for the frame to end
    clear_obs();
    load_i = 1'b1;
    data_i = 32'hFFFF_0000;
    step();
    data_i = 32'h1234_5678;
    repeat (W + 1 + PAR) step();
    load_i = 1'b0;
    check("t3_second_busy", busy_o, 1);
    check("t3_second_first_bit", ser_out_o, 0);
    wait_idle("t3");
    check("t3_word0", word_at(0), 32'hFFFF_0000);
    check("t3_word1", word_at(W + PAR), 32'h1234_5678);
    check("t3_nbits", stream.size(), 2 * (W + PAR));
    check("t3_fe_count", fe_cyc.size(), 2);
    check("t3_gap", sv_rise[1] - sv_rise[0], W + 1 + PAR);

`ifdef REG32_SERIAL_PARITY_EN
    clear_obs();
    send(32'h0000_0001);
    wait_idle("t4");
    check("t4_word", word_at(0), 32'h0000_0001);
    check("t4_parity", stream[W], 1);
`endif

    // Reset mid-frame
    clear_obs();
    send(32'hFFFF_0000);
    repeat (9) step();
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", busy_o, 0);
    check("t5_rst_valid", ser_valid_o, 0);
    check("t5_rst_out", ser_out_o, 0);
    check("t5_rst_fe", frame_end_o, 0);
    repeat (2) step();
    rst_n = 1'b1;
    send(32'h8000_0000);
    check("t5_first_bit", ser_out_o, 1);
    check("t5_first_valid", ser_valid_o, 1);
    check("t5_no_fe", fe_cyc.size(), 0);
    wait_idle("t5");
    check("t5_fe_count", fe_cyc.size(), 1);

    // Back-to-back: next load presented during DONE
    clear_obs();
    a = $urandom;
    b = $urandom;
    send(a);
    n = 0;
    while (frame_end_o !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("t6_fe_timeout", (n < 200), 1);
    send(b);
    check("t6_busy", busy_o, 1);
    check("t6_valid", ser_valid_o, 1);
    check("t6_first_bit", ser_out_o, b[W-1]);
    wait_idle("t6");
    check("t6_gap", sv_rise[1] - sv_rise[0], W + 1 + PAR);
    check("t6_word0", word_at(0), a);
    check("t6_word1", word_at(W + PAR), b);

    // Random traffic with occasional asynchronous resets
    for (int i = 0; i < 2000; i++) begin
      load_i = ($urandom_range(0, 3) == 0);
      data_i = $urandom;
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end
    load_i = 1'b0;
    wait_idle("rand");
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
